// File: rtl/lint_axi_arbiter.sv
// Round-robin arbiter sharing one single-outstanding lint-to-AXI bridge port
// among N_MASTERS lint requesters; one transaction in flight at a time.
module lint_axi_arbiter #(
  parameter int unsigned N_MASTERS  = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = 4,
  parameter int unsigned ID_WIDTH   = 16,
  parameter int unsigned AUX_WIDTH  = 10
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [N_MASTERS-1:0]            m_req_i,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [N_MASTERS-1:0]            m_we_i,
  input  logic [N_MASTERS*32-1:0]         m_wdata_i,
  input  logic [N_MASTERS*BE_WIDTH-1:0]   m_be_i,
  input  logic [N_MASTERS*ID_WIDTH-1:0]   m_ID_i,
  input  logic [N_MASTERS*AUX_WIDTH-1:0]  m_aux_i,
  output logic [N_MASTERS-1:0]            m_gnt_o,
  output logic [N_MASTERS-1:0]            m_rvalid_o,
  output logic [31:0]                     m_rdata_o,
  output logic                            m_ropc_o,
  output logic [ID_WIDTH-1:0]             m_rID_o,
  output logic [AUX_WIDTH-1:0]            m_raux_o,
  output logic                            s_req_o,
  output logic [ADDR_WIDTH-1:0]           s_addr_o,
  output logic                            s_we_o,
  output logic [31:0]                     s_wdata_o,
  output logic [BE_WIDTH-1:0]             s_be_o,
  output logic [ID_WIDTH-1:0]             s_ID_o,
  output logic [AUX_WIDTH-1:0]            s_aux_o,
  input  logic                            s_gnt_i,
  input  logic                            s_rvalid_i,
  input  logic [31:0]                     s_rdata_i,
  input  logic                            s_ropc_i,
  input  logic [ID_WIDTH-1:0]             s_rID_i,
  input  logic [AUX_WIDTH-1:0]            s_raux_i
);

  localparam int unsigned IDX_WIDTH = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_WIDTH-1:0] sel_q, sel_d;
  logic [IDX_WIDTH-1:0] owner_q, owner_d;
  logic                 lock_q, lock_d;

  logic [IDX_WIDTH-1:0] rr_winner, winner, rr_next;
  logic [IDX_WIDTH:0]   cand;
  logic                 idle, fire;

  logic [ADDR_WIDTH-1:0] addr_arr  [N_MASTERS];
  logic [31:0]           wdata_arr [N_MASTERS];
  logic [BE_WIDTH-1:0]   be_arr    [N_MASTERS];
  logic [ID_WIDTH-1:0]   id_arr    [N_MASTERS];
  logic [AUX_WIDTH-1:0]  aux_arr   [N_MASTERS];

  assign idle = (state_q == IDLE);

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
    assign addr_arr[gi]   = m_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi]  = m_wdata_i[gi*32 +: 32];
    assign be_arr[gi]     = m_be_i[gi*BE_WIDTH +: BE_WIDTH];
    assign id_arr[gi]     = m_ID_i[gi*ID_WIDTH +: ID_WIDTH];
    assign aux_arr[gi]    = m_aux_i[gi*AUX_WIDTH +: AUX_WIDTH];
    assign m_gnt_o[gi]    = fire && (winner == IDX_WIDTH'(gi));
    assign m_rvalid_o[gi] = !idle && s_rvalid_i && (owner_q == IDX_WIDTH'(gi));
  end

  // Scan from the highest offset down so the nearest requester to rr_ptr_q wins.
  always_comb begin
    rr_winner = rr_ptr_q;
    cand      = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (IDX_WIDTH+1)'(i);
      if (cand >= (IDX_WIDTH+1)'(N_MASTERS)) begin
        cand = cand - (IDX_WIDTH+1)'(N_MASTERS);
      end
      if (m_req_i[cand[IDX_WIDTH-1:0]]) begin
        rr_winner = cand[IDX_WIDTH-1:0];
      end
    end
  end

  assign winner  = lock_q ? sel_q : rr_winner;
  assign rr_next = (winner == IDX_WIDTH'(N_MASTERS - 1)) ? '0 : winner + 1'b1;
  assign s_req_o = idle && m_req_i[winner];
  assign fire    = s_req_o && s_gnt_i;

  assign s_addr_o  = addr_arr[winner];
  assign s_we_o    = m_we_i[winner];
  assign s_wdata_o = wdata_arr[winner];
  assign s_be_o    = be_arr[winner];
  assign s_ID_o    = id_arr[winner];
  assign s_aux_o   = aux_arr[winner];

  assign m_rdata_o = s_rdata_i;
  assign m_ropc_o  = s_ropc_i;
  assign m_rID_o   = s_rID_i;
  assign m_raux_o  = s_raux_i;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    owner_d  = owner_q;
    lock_d   = lock_q;
    if (idle) begin
      if (fire) begin
        owner_d  = winner;
        rr_ptr_d = rr_next;
        lock_d   = 1'b0;
        state_d  = BUSY;
      end else if (s_req_o) begin
        lock_d = 1'b1;
        sel_d  = winner;
      end else begin
        // Also releases a lock whose master withdrew its request.
        lock_d = 1'b0;
      end
    end else if (s_rvalid_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      owner_q  <= '0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      owner_q  <= owner_d;
      lock_q   <= lock_d;
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(m_gnt_o));
  a_rvalid_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(m_rvalid_o));
  a_no_req_busy: assert property (@(posedge clk_i) disable iff (!rst_ni) (state_q == BUSY) |-> !s_req_o);

endmodule

// File: tb/tb_lint_axi_arbiter.sv
// Self-checking bench for lint_axi_arbiter: directed scenarios on a 4-master
// and a 3-master instance, then randomized traffic against a reference model.
module tb_lint_axi_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // 4-master instance
  logic [3:0]   m_req, m_we, m_gnt, m_rvalid;
  logic [127:0] m_addr, m_wdata;
  logic [15:0]  m_be;
  logic [63:0]  m_ID;
  logic [39:0]  m_aux;
  logic [31:0]  m_rdata, s_addr, s_wdata, s_rdata;
  logic         m_ropc, s_req, s_we, s_gnt, s_rvalid, s_ropc;
  logic [15:0]  m_rID, s_ID, s_rID;
  logic [9:0]   m_raux, s_aux, s_raux;
  logic [3:0]   s_be;

  // 3-master instance
  logic [2:0]  m_req3, m_we3, m_gnt3, m_rvalid3;
  logic [95:0] m_addr3, m_wdata3;
  logic [11:0] m_be3;
  logic [47:0] m_ID3;
  logic [29:0] m_aux3;
  logic [31:0] m_rdata3, s_addr3, s_wdata3;
  logic        m_ropc3, s_req3, s_we3, s_gnt3, s_rvalid3;
  logic [15:0] m_rID3, s_ID3;
  logic [9:0]  m_raux3, s_aux3;
  logic [3:0]  s_be3;

  lint_axi_arbiter #(.N_MASTERS(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we), .m_wdata_i(m_wdata),
    .m_be_i(m_be), .m_ID_i(m_ID), .m_aux_i(m_aux),
    .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .m_ropc_o(m_ropc),
    .m_rID_o(m_rID), .m_raux_o(m_raux),
    .s_req_o(s_req), .s_addr_o(s_addr), .s_we_o(s_we), .s_wdata_o(s_wdata),
    .s_be_o(s_be), .s_ID_o(s_ID), .s_aux_o(s_aux),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_ropc_i(s_ropc),
    .s_rID_i(s_rID), .s_raux_i(s_raux)
  );

  lint_axi_arbiter #(.N_MASTERS(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(m_req3), .m_addr_i(m_addr3), .m_we_i(m_we3), .m_wdata_i(m_wdata3),
    .m_be_i(m_be3), .m_ID_i(m_ID3), .m_aux_i(m_aux3),
    .m_gnt_o(m_gnt3), .m_rvalid_o(m_rvalid3), .m_rdata_o(m_rdata3), .m_ropc_o(m_ropc3),
    .m_rID_o(m_rID3), .m_raux_o(m_raux3),
    .s_req_o(s_req3), .s_addr_o(s_addr3), .s_we_o(s_we3), .s_wdata_o(s_wdata3),
    .s_be_o(s_be3), .s_ID_o(s_ID3), .s_aux_o(s_aux3),
    .s_gnt_i(s_gnt3), .s_rvalid_i(s_rvalid3), .s_rdata_i(s_rdata), .s_ropc_i(s_ropc),
    .s_rID_i(s_rID), .s_raux_i(s_raux)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m_req = '0; m_addr = '0; m_we = '0; m_wdata = '0; m_be = '0; m_ID = '0; m_aux = '0;
    s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_ropc = 1'b0; s_rID = '0; s_raux = '0;
    m_req3 = '0; m_addr3 = '0; m_we3 = '0; m_wdata3 = '0; m_be3 = '0; m_ID3 = '0; m_aux3 = '0;
    s_gnt3 = 1'b0; s_rvalid3 = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    s_gnt = 1'b1;
    s_rvalid = 1'b1;
    tick();
    tick();
    vectors++;
    if (m_gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_gnt: got %b want 0000", m_gnt);
    end
    vectors++;
    if (m_rvalid !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_rvalid: got %b want 0000", m_rvalid);
    end
    vectors++;
    if (s_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_sreq: got %b want 0", s_req);
    end
    rst_n = 1'b1;
    s_gnt = 1'b0;
    s_rvalid = 1'b0;
    tick();
    vectors++;
    if (u_dut4.rr_ptr_q !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_rr_ptr: got %0d want 0", u_dut4.rr_ptr_q);
    end
    $display("reset: checked idle outputs and pointer");
  endtask

  task automatic test_single_read();
    m_req = 4'b0100;
    m_addr[2*32 +: 32] = 32'h1C00_0010;
    s_gnt = 1'b1;
    settle();
    vectors++;
    if (m_gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL read_gnt: got %b want 0100", m_gnt);
    end
    vectors++;
    if (s_addr !== 32'h1C00_0010 || s_req !== 1'b1 || s_we !== 1'b0) begin
      miscompares++;
      $display("FAIL read_req: got req=%b addr=%h we=%b want 1 1c000010 0", s_req, s_addr, s_we);
    end
    tick();
    m_req = '0;
    s_gnt = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      settle();
      vectors++;
      if (m_rvalid !== 4'b0000 || s_req !== 1'b0) begin
        miscompares++;
        $display("FAIL read_wait%0d: got rvalid=%b sreq=%b want 0000 0", c, m_rvalid, s_req);
      end
      tick();
    end
    s_rvalid = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    settle();
    vectors++;
    if (m_rvalid !== 4'b0100 || m_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL read_resp: got rvalid=%b rdata=%h want 0100 deadbeef", m_rvalid, m_rdata);
    end
    tick();
    s_rvalid = 1'b0;
    vectors++;
    if (u_dut4.rr_ptr_q !== 2'd3) begin
      miscompares++;
      $display("FAIL read_rr_ptr: got %0d want 3", u_dut4.rr_ptr_q);
    end
    $display("single_read: master 2 read addr 1c000010 rdata deadbeef");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    do_reset();
    m_req = 4'b1111;
    s_gnt = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << (g % 4);
      s_rvalid = 1'b0;
      settle();
      vectors++;
      if (m_gnt !== exp || s_req !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_gnt%0d: got gnt=%b sreq=%b want %b 1", g, m_gnt, s_req, exp);
      end
      tick();
      s_rvalid = 1'b1;
      settle();
      vectors++;
      if (m_gnt !== 4'b0000 || s_req !== 1'b0 || m_rvalid !== exp) begin
        miscompares++;
        $display("FAIL b2b_resp%0d: got gnt=%b sreq=%b rvalid=%b want 0000 0 %b",
                 g, m_gnt, s_req, m_rvalid, exp);
      end
      tick();
      $display("back_to_back: grant %0d to master %0d", g, g % 4);
    end
    clear_inputs();
  endtask

  task automatic test_stall_lock();
    do_reset();
    m_addr[0 +: 32]  = 32'hA000_0000;
    m_addr[32 +: 32] = 32'hB000_1111;
    m_req = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) m_req[0] = 1'b1;
      settle();
      vectors++;
      if (s_addr !== 32'hB000_1111 || s_req !== 1'b1 || m_gnt !== 4'b0000) begin
        miscompares++;
        $display("FAIL stall_c%0d: got addr=%h sreq=%b gnt=%b want b0001111 1 0000",
                 c, s_addr, s_req, m_gnt);
      end
      tick();
    end
    s_gnt = 1'b1;
    settle();
    vectors++;
    if (m_gnt !== 4'b0010 || s_addr !== 32'hB000_1111) begin
      miscompares++;
      $display("FAIL stall_grant1: got gnt=%b addr=%h want 0010 b0001111", m_gnt, s_addr);
    end
    tick();
    m_req[1] = 1'b0;
    s_gnt = 1'b0;
    s_rvalid = 1'b1;
    settle();
    vectors++;
    if (m_rvalid !== 4'b0010) begin
      miscompares++;
      $display("FAIL stall_resp1: got %b want 0010", m_rvalid);
    end
    tick();
    s_rvalid = 1'b0;
    s_gnt = 1'b1;
    settle();
    vectors++;
    if (m_gnt !== 4'b0001 || s_addr !== 32'hA000_0000) begin
      miscompares++;
      $display("FAIL stall_grant0: got gnt=%b addr=%h want 0001 a0000000", m_gnt, s_addr);
    end
    tick();
    m_req = '0;
    s_gnt = 1'b0;
    s_rvalid = 1'b1;
    settle();
    vectors++;
    if (m_rvalid !== 4'b0001) begin
      miscompares++;
      $display("FAIL stall_resp0: got %b want 0001", m_rvalid);
    end
    tick();
    s_rvalid = 1'b0;
    $display("stall_lock: master 1 held through 5 stall cycles, then master 0");
  endtask

  task automatic test_write();
    m_req = 4'b1000;
    m_we = 4'b1000;
    m_be[12 +: 4] = 4'b0011;
    m_wdata[96 +: 32] = 32'h1234_5678;
    m_ID[48 +: 16] = 16'h00A5;
    s_gnt = 1'b1;
    settle();
    vectors++;
    if (m_gnt !== 4'b1000 || s_we !== 1'b1 || s_be !== 4'b0011) begin
      miscompares++;
      $display("FAIL write_req: got gnt=%b we=%b be=%b want 1000 1 0011", m_gnt, s_we, s_be);
    end
    vectors++;
    if (s_ID !== 16'h00A5 || s_wdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL write_payload: got id=%h wdata=%h want 00a5 12345678", s_ID, s_wdata);
    end
    tick();
    clear_inputs();
    s_rvalid = 1'b1;
    s_ropc = 1'b1;
    s_rID = 16'h00A5;
    settle();
    vectors++;
    if (m_rvalid !== 4'b1000 || m_ropc !== 1'b1 || m_rID !== 16'h00A5) begin
      miscompares++;
      $display("FAIL write_resp: got rvalid=%b ropc=%b rid=%h want 1000 1 00a5",
               m_rvalid, m_ropc, m_rID);
    end
    tick();
    clear_inputs();
    $display("write: master 3 be 0011 wdata 12345678 id 00a5 ropc 1");
  endtask

  task automatic test_n3_wrap();
    m_req3 = 3'b010;
    s_gnt3 = 1'b1;
    settle();
    vectors++;
    if (m_gnt3 !== 3'b010) begin
      miscompares++;
      $display("FAIL n3_first: got %b want 010", m_gnt3);
    end
    tick();
    m_req3 = 3'b000;
    s_rvalid3 = 1'b1;
    tick();
    s_rvalid3 = 1'b0;
    m_req3 = 3'b101;
    settle();
    vectors++;
    if (m_gnt3 !== 3'b100) begin
      miscompares++;
      $display("FAIL n3_ptr2_winner: got %b want 100", m_gnt3);
    end
    tick();
    m_req3 = 3'b001;
    s_rvalid3 = 1'b1;
    settle();
    vectors++;
    if (m_rvalid3 !== 3'b100 || s_req3 !== 1'b0) begin
      miscompares++;
      $display("FAIL n3_resp: got rvalid=%b sreq=%b want 100 0", m_rvalid3, s_req3);
    end
    tick();
    vectors++;
    if (u_dut3.rr_ptr_q !== 2'd0) begin
      miscompares++;
      $display("FAIL n3_wrap_ptr: got %0d want 0", u_dut3.rr_ptr_q);
    end
    s_rvalid3 = 1'b0;
    settle();
    vectors++;
    if (m_gnt3 !== 3'b001) begin
      miscompares++;
      $display("FAIL n3_wrap_winner: got %b want 001", m_gnt3);
    end
    tick();
    m_req3 = '0;
    s_gnt3 = 1'b0;
    s_rvalid3 = 1'b1;
    tick();
    s_rvalid3 = 1'b0;
    $display("n3_wrap: pointer 2 -> master 2, wrap to 0 -> master 0");
  endtask

  task automatic test_reset_busy();
    m_req = 4'b0001;
    s_gnt = 1'b1;
    tick();
    m_req = '0;
    s_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    s_rvalid = 1'b1;
    #1;
    vectors++;
    if (m_rvalid !== 4'b0000) begin
      miscompares++;
      $display("FAIL rstbusy_during: got %b want 0000", m_rvalid);
    end
    tick();
    rst_n = 1'b1;
    settle();
    vectors++;
    if (m_rvalid !== 4'b0000) begin
      miscompares++;
      $display("FAIL rstbusy_late_rvalid: got %b want 0000", m_rvalid);
    end
    tick();
    vectors++;
    if (u_dut4.rr_ptr_q !== 2'd0) begin
      miscompares++;
      $display("FAIL rstbusy_rr_ptr: got %0d want 0", u_dut4.rr_ptr_q);
    end
    s_rvalid = 1'b0;
    m_req = 4'b0100;
    s_gnt = 1'b1;
    settle();
    vectors++;
    if (m_gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL rstbusy_idle_grant: got %b want 0100", m_gnt);
    end
    tick();
    clear_inputs();
    s_rvalid = 1'b1;
    tick();
    s_rvalid = 1'b0;
    $display("reset_busy: late response dropped, arbiter idle");
  endtask

  // Reference model: plain round-robin rule with a held selection while stalled.
  function automatic int rr_pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic test_random();
    bit md_busy = 0;
    bit md_lock = 0;
    int md_rr = 0, md_sel = 0, md_owner = 0, w;
    bit exp_sreq;
    logic [3:0] exp_gnt, exp_rvalid;
    logic [31:0] exp_addr;
    int grants = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      m_req = 4'($urandom_range(0, 15));
      if (md_lock && $urandom_range(0, 7) != 0) m_req[md_sel] = 1'b1;
      m_addr = {$urandom, $urandom, $urandom, $urandom};
      m_wdata = {$urandom, $urandom, $urandom, $urandom};
      m_we = 4'($urandom);
      s_gnt = 1'($urandom_range(0, 1));
      s_rvalid = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      settle();
      w = md_lock ? md_sel : rr_pick(m_req, md_rr);
      exp_sreq = !md_busy && (w >= 0) && m_req[w];
      exp_gnt = (exp_sreq && s_gnt) ? (4'b0001 << w) : 4'b0000;
      exp_rvalid = (md_busy && s_rvalid) ? (4'b0001 << md_owner) : 4'b0000;
      exp_addr = exp_sreq ? m_addr[w*32 +: 32] : 32'h0;
      vectors++;
      if (s_req !== exp_sreq || m_gnt !== exp_gnt) begin
        miscompares++;
        $display("FAIL rand%0d_req: got sreq=%b gnt=%b want %b %b", n, s_req, m_gnt, exp_sreq, exp_gnt);
      end
      vectors++;
      if (m_rvalid !== exp_rvalid) begin
        miscompares++;
        $display("FAIL rand%0d_rvalid: got %b want %b", n, m_rvalid, exp_rvalid);
      end
      if (exp_sreq) begin
        vectors++;
        if (s_addr !== exp_addr) begin
          miscompares++;
          $display("FAIL rand%0d_addr: got %h want %h", n, s_addr, exp_addr);
        end
      end
      if (exp_rvalid != 4'b0000) begin
        vectors++;
        if (m_rdata !== s_rdata) begin
          miscompares++;
          $display("FAIL rand%0d_rdata: got %h want %h", n, m_rdata, s_rdata);
        end
      end
      if (md_busy) begin
        if (s_rvalid) md_busy = 0;
      end else if (exp_sreq && s_gnt) begin
        md_busy = 1;
        md_owner = w;
        md_rr = (w + 1) % 4;
        md_lock = 0;
        grants++;
      end else if (exp_sreq) begin
        md_lock = 1;
        md_sel = w;
      end else begin
        md_lock = 0;
      end
      tick();
    end
    clear_inputs();
    $display("random: 400 cycles, %0d grants modelled", grants);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_stall_lock();
    test_write();
    test_n3_wrap();
    test_reset_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lint_axi_arbiter.md
Name: lint_axi_arbiter

Overview:
- Round-robin arbiter that shares one single-outstanding lint-to-AXI bridge port between N_MASTERS lint requesters (e.g. cores, DMA, debug unit).
- Sits directly upstream of the bridge.
- Sequences exactly one transaction at a time: arbitrate, forward, wait for grant, wait for response, route the response back to the winning requester.

Parameters:
- N_MASTERS, 4, number of upstream lint requesters (>=2).
- ADDR_WIDTH, 32, address width.
- BE_WIDTH, 4, byte-enable width.
- ID_WIDTH, 16, transaction ID width.
- AUX_WIDTH, 10, auxiliary sideband width.
- IDX_WIDTH, $clog2(N_MASTERS), master index width (derived, not overridden).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- m_req_i  in  N_MASTERS  per-master request.
- m_addr_i  in  N_MASTERS*ADDR_WIDTH  packed addresses; master k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- m_we_i  in  N_MASTERS  write enable.
- m_wdata_i  in  N_MASTERS*32  write data.
- m_be_i  in  N_MASTERS*BE_WIDTH  byte enables.
- m_ID_i  in  N_MASTERS*ID_WIDTH  transaction IDs.
- m_aux_i  in  N_MASTERS*AUX_WIDTH  aux sideband.
- m_gnt_o  out  N_MASTERS  per-master grant, one-hot or zero.
- m_rvalid_o  out  N_MASTERS  per-master response valid, one-hot or zero.
- m_rdata_o  out  32  response data, shared by all masters.
- m_ropc_o  out  1  response error flag, shared.
- m_rID_o  out  ID_WIDTH  response ID, shared.
- m_raux_o  out  AUX_WIDTH  response aux, shared.
- s_req_o  out  1  request to bridge.
- s_addr_o  out  ADDR_WIDTH  address to bridge.
- s_we_o  out  1  write enable to bridge.
- s_wdata_o  out  32  write data to bridge.
- s_be_o  out  BE_WIDTH  byte enables to bridge.
- s_ID_o  out  ID_WIDTH  ID to bridge.
- s_aux_o  out  AUX_WIDTH  aux to bridge.
- s_gnt_i  in  1  bridge grant.
- s_rvalid_i  in  1  bridge response valid.
- s_rdata_i  in  32  bridge response data.
- s_ropc_i  in  1  bridge response error.
- s_rID_i  in  ID_WIDTH  bridge response ID.
- s_raux_i  in  AUX_WIDTH  bridge response aux.

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i.
  - State IDLE; rr_ptr_q=0; lock_q=0; sel_q=0; owner_q=0.
  - All outputs are combinational from state. At reset: m_gnt_o=0, m_rvalid_o=0, s_req_o=0.
  - s_* payload and m_r* data pass through, but are qualified by valid/req.
- State IDLE:
  - If lock_q=0: winner = first k with m_req_i[k]=1, searching rr_ptr_q, rr_ptr_q+1, ... mod N_MASTERS.
  - If lock_q=1: winner = sel_q.
  - s_req_o = m_req_i[winner]; s_* payload = winner's fields.
  - m_gnt_o[winner] = s_gnt_i & s_req_o, combinational and same cycle.
  - On s_req_o & s_gnt_i: owner_q<=winner; rr_ptr_q<=(winner+1) mod N_MASTERS; lock_q<=0; go BUSY.
  - On s_req_o & !s_gnt_i: lock_q<=1; sel_q<=winner. The selection is held until granted; later higher-priority requests do not preempt.
  - If the locked master drops its request (protocol violation): s_req_o=0 that cycle; lock_q<=0; arbitration restarts the next cycle.
  - No requests: stay in IDLE; rr_ptr_q is unchanged.
- State BUSY:
  - s_req_o=0; m_gnt_o=0.
  - On s_rvalid_i: m_rvalid_o[owner_q]=1, same cycle; m_rdata_o/m_ropc_o/m_rID_o/m_raux_o = s_* response fields; go IDLE.
  - No new request is issued in the response cycle. Minimum spacing between grants is 2 cycles.
  - s_rvalid_i in IDLE (spurious) is ignored: m_rvalid_o=0.
- Latency:
  - Grant is zero-cycle, combinational through the arbiter.
  - Response is zero-cycle, combinational routing.
- Width rules: rr_ptr_q wraps from N_MASTERS-1 to 0. Non-power-of-two N_MASTERS must wrap correctly, e.g. 3 gives 2->0.
- Reset mid-transaction forces IDLE and drops the owner. A late s_rvalid_i after reset is ignored.
- Assertions (non-synthesis):
  - m_gnt_o and m_rvalid_o are onehot0.
  - s_req_o is never high in BUSY.

Test Plan:
- Single master 2, read, addr 0x1C000010; bridge grants in cycle 0 and returns rdata 0xDEADBEEF 3 cycles later -> m_gnt_o=4'b0100 in cycle 0; m_rvalid_o=4'b0100 with m_rdata_o=0xDEADBEEF; rr_ptr_q=3.
- All four masters request continuously, bridge always grants with 1-cycle response -> grants issued in order 0,1,2,3,0; one every 2 cycles; never two grants outstanding.
- Master 1 requests, bridge stalls grant 5 cycles; master 0 raises a request in cycle 2 -> s_addr_o stays master 1's address all 5 cycles; master 1 granted first, then master 0.
- Write from master 3 with be 4'b0011, wdata 0x12345678, ID 0x00A5; response ropc=1 -> s_we_o=1, s_be_o=0011, s_ID_o=0x00A5; m_rvalid_o[3]=1, m_ropc_o=1, m_rID_o=0x00A5.
- N_MASTERS=3; masters 2 and 0 requesting with rr_ptr_q=2 -> master 2 wins; rr_ptr_q wraps to 0; master 0 wins next.
- rst_ni pulsed low while in BUSY, then s_rvalid_i=1 after release -> all m_rvalid_o=0; state IDLE; rr_ptr_q=0.
